spi_master_core: RTL



---
 rtl/spi_master_core.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/spi_master_core.sv
// SPI master engine: serializes bytes from a valid/ready port onto SCLK/MOSI/CS_N
// and returns the byte captured from MISO as a one-cycle receive pulse.
module spi_master_core #(
  parameter int DATA_W   = 8,
  parameter int HALF_DIV = 3,
  parameter bit CPOL     = 1'b0,
  parameter bit CPHA     = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_keep,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic              cs_n
);

  localparam int DIV_W  = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam int EDGE_W = $clog2(2 * DATA_W);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(HALF_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_e;

  state_e              state_q, state_d;
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [EDGE_W-1:0]   edge_cnt_q, edge_cnt_d;
  logic [DATA_W-1:0]   tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0]   rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic                keep_q, keep_d;
  logic                sclk_q, sclk_d;
  logic                mosi_q, mosi_d;
  logic                cs_n_q, cs_n_d;
  logic                rx_valid_q, rx_valid_d;

  logic                tick;
  logic                accept;
  logic                edge_now;
  logic                sample_edge;
  logic                drive_edge;
  logic [EDGE_W-1:0]   edge_idx;

  assign tick     = (div_cnt_q == DIV_LAST);
  assign tx_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign accept   = tx_valid & tx_ready;

  // The final SETUP tick produces edge 0; each SHIFT tick produces the edge after edge_cnt_q.
  assign edge_now    = tick && ((state_q == SETUP) || (state_q == SHIFT));
  assign edge_idx    = (state_q == SETUP) ? '0 : edge_cnt_q + EDGE_W'(1);
  assign sample_edge = (edge_idx[0] == CPHA);
  assign drive_edge  = CPHA ? !edge_idx[0] : (edge_idx[0] && (edge_idx != EDGE_LAST));

  always_comb begin
    state_d    = state_q;
    div_cnt_d  = '0;
    edge_cnt_d = edge_cnt_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    keep_d     = keep_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    cs_n_d     = cs_n_q;
    rx_valid_d = 1'b0;

    if ((state_q != IDLE) && !tick) begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
    end

    if (edge_now) begin
      sclk_d = ~sclk_q;
      if (sample_edge) begin
        rx_shift_d = (rx_shift_q << 1) | DATA_W'(miso);
      end
      // CPHA=1 re-drives the current MSB before shifting; CPHA=0 moves to the next bit.
      if (drive_edge) begin
        tx_shift_d = tx_shift_q << 1;
        mosi_d     = CPHA ? tx_shift_q[DATA_W-1] : tx_shift_d[DATA_W-1];
      end
    end

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d    = SETUP;
          tx_shift_d = tx_data;
          keep_d     = tx_keep;
          mosi_d     = tx_data[DATA_W-1];
          cs_n_d     = 1'b0;
        end
      end
      SETUP: begin
        if (tick) begin
          state_d    = SHIFT;
          edge_cnt_d = '0;
        end
      end
      SHIFT: begin
        if (tick) begin
          edge_cnt_d = edge_idx;
          if (edge_idx == EDGE_LAST) begin
            state_d    = HOLD;
            rx_data_d  = rx_shift_d;
            rx_valid_d = 1'b1;
          end
        end
      end
      HOLD: begin
        if (tick) begin
          if (keep_q) begin
            state_d = IDLE;
          end else begin
            state_d = GAP;
            cs_n_d  = 1'b1;
          end
        end
      end
      GAP: begin
        if (tick) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      div_cnt_q  <= '0;
      edge_cnt_q <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      keep_q     <= 1'b0;
      sclk_q     <= CPOL;
      mosi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      keep_q     <= keep_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign sclk     = sclk_q;
  assign mosi     = mosi_q;
  assign cs_n     = cs_n_q;

endmodule
